// File: rtl/imm_decode_stage.sv
// RV32/RV64 immediate decoder with one-cycle registered output and a two-entry skid buffer.
// The skid entry absorbs one accept while the output stalls; in_ready is simply "skid empty".
module imm_decode_stage #(
  parameter int XLEN    = 32,
  parameter int TAG_W   = 8,
  parameter bit EN_ZIMM = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic [TAG_W-1:0] out_tag
);

  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;
  localparam logic [2:0] FMT_Z    = 3'd6;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [2:0]       fmt;
    logic [TAG_W-1:0] tag;
  } ent_t;

  logic [2:0]  dec_fmt;
  logic [31:0] dec_v32;
  logic        sx;
  ent_t        dec;

  logic m_vld_q, m_vld_d, k_vld_q, k_vld_d;
  logic m_ld, k_ld;
  ent_t m_q, m_d, k_q;
  logic acc;

  always_comb begin
    dec_fmt = FMT_NONE;
    case (in_instr[6:0])
      7'b0000011, 7'b0010011, 7'b1100111: dec_fmt = FMT_I;
      7'b0011011: dec_fmt = (XLEN == 64) ? FMT_I : FMT_NONE;
      7'b1110011: dec_fmt = (EN_ZIMM && in_instr[14]) ? FMT_Z : FMT_I;
      7'b0100011: dec_fmt = FMT_S;
      7'b1100011: dec_fmt = FMT_B;
      7'b0110111, 7'b0010111: dec_fmt = FMT_U;
      7'b1101111: dec_fmt = FMT_J;
      default:    dec_fmt = FMT_NONE;
    endcase
  end

  // Built as 32-bit signed values; Z has a zero top bit so the final widening stays a zero-extend.
  assign sx = in_instr[31];
  always_comb begin
    dec_v32 = 32'd0;
    case (dec_fmt)
      FMT_I:   dec_v32 = {{20{sx}}, in_instr[31:20]};
      FMT_S:   dec_v32 = {{20{sx}}, in_instr[31:25], in_instr[11:7]};
      FMT_B:   dec_v32 = {{20{sx}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
      FMT_U:   dec_v32 = {in_instr[31:12], 12'd0};
      FMT_J:   dec_v32 = {{12{sx}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
      FMT_Z:   dec_v32 = {27'd0, in_instr[19:15]};
      default: dec_v32 = 32'd0;
    endcase
  end

  assign dec.imm = XLEN'($signed(dec_v32));
  assign dec.fmt = dec_fmt;
  assign dec.tag = in_tag;

  assign in_ready = ~k_vld_q;
  assign acc      = in_valid & in_ready;

  always_comb begin
    m_vld_d = m_vld_q;
    k_vld_d = k_vld_q;
    m_ld    = 1'b0;
    k_ld    = 1'b0;
    m_d     = dec;
    if (flush) begin
      m_vld_d = 1'b0;
      k_vld_d = 1'b0;
    end else if (!m_vld_q || out_ready) begin
      // K can only be full while M is full, so this branch means M is being drained.
      if (k_vld_q) begin
        m_d     = k_q;
        m_ld    = 1'b1;
        m_vld_d = 1'b1;
        k_vld_d = 1'b0;
      end else begin
        m_ld    = acc;
        m_vld_d = acc;
      end
    end else if (acc) begin
      k_ld    = 1'b1;
      k_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_vld_q <= 1'b0;
      k_vld_q <= 1'b0;
      m_q     <= '0;
      k_q     <= '0;
    end else begin
      m_vld_q <= m_vld_d;
      k_vld_q <= k_vld_d;
      if (m_ld) m_q <= m_d;
      if (k_ld) k_q <= dec;
    end
  end

  assign out_valid = m_vld_q;
  assign out_imm   = m_q.imm;
  assign out_fmt   = m_q.fmt;
  assign out_tag   = m_q.tag;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Directed bench: three configurations (RV32+zimm, RV64+zimm, RV32 without zimm) share one input stream.
module tb_imm_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [7:0]  in_tag;
  logic        out_ready;

  logic        a_in_ready, b_in_ready, c_in_ready;
  logic        a_vld, b_vld, c_vld;
  logic [31:0] a_imm, c_imm;
  logic [63:0] b_imm;
  logic [2:0]  a_fmt, b_fmt, c_fmt;
  logic [7:0]  a_tag, b_tag, c_tag;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  imm_decode_stage #(.XLEN(32), .TAG_W(8), .EN_ZIMM(1'b1)) u_a (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_instr(in_instr), .in_tag(in_tag), .out_valid(a_vld), .out_ready(out_ready),
    .out_imm(a_imm), .out_fmt(a_fmt), .out_tag(a_tag));

  imm_decode_stage #(.XLEN(64), .TAG_W(8), .EN_ZIMM(1'b1)) u_b (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_instr(in_instr), .in_tag(in_tag), .out_valid(b_vld), .out_ready(out_ready),
    .out_imm(b_imm), .out_fmt(b_fmt), .out_tag(b_tag));

  imm_decode_stage #(.XLEN(32), .TAG_W(8), .EN_ZIMM(1'b0)) u_c (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(c_in_ready),
    .in_instr(in_instr), .in_tag(in_tag), .out_valid(c_vld), .out_ready(out_ready),
    .out_imm(c_imm), .out_fmt(c_fmt), .out_tag(c_tag));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [31:0] imm_a;
    logic [2:0]  fmt_a;
    logic [63:0] imm_b;
    logic [2:0]  fmt_b;
    logic [31:0] imm_c;
    logic [2:0]  fmt_c;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs[NV];
  logic [7:0] got[$];
  logic [31:0] held_imm;
  logic i_fire, o_fire;
  logic [7:0] o_tag;

  initial begin
    vecs[0]  = '{32'hFFF00093, 32'hFFFFFFFF, 3'd1, 64'hFFFFFFFFFFFFFFFF, 3'd1, 32'hFFFFFFFF, 3'd1};
    vecs[1]  = '{32'hFE000EE3, 32'hFFFFFFFC, 3'd3, 64'hFFFFFFFFFFFFFFFC, 3'd3, 32'hFFFFFFFC, 3'd3};
    vecs[2]  = '{32'h0000006F, 32'h00000000, 3'd5, 64'h0000000000000000, 3'd5, 32'h00000000, 3'd5};
    vecs[3]  = '{32'h800000B7, 32'h80000000, 3'd4, 64'hFFFFFFFF80000000, 3'd4, 32'h80000000, 3'd4};
    vecs[4]  = '{32'hFFF0809B, 32'h00000000, 3'd0, 64'hFFFFFFFFFFFFFFFF, 3'd1, 32'h00000000, 3'd0};
    vecs[5]  = '{32'h3402D073, 32'h00000005, 3'd6, 64'h0000000000000005, 3'd6, 32'h00000340, 3'd1};
    vecs[6]  = '{32'h0020A423, 32'h00000008, 3'd2, 64'h0000000000000008, 3'd2, 32'h00000008, 3'd2};
    vecs[7]  = '{32'hFE112E23, 32'hFFFFFFFC, 3'd2, 64'hFFFFFFFFFFFFFFFC, 3'd2, 32'hFFFFFFFC, 3'd2};
    vecs[8]  = '{32'h12345017, 32'h12345000, 3'd4, 64'h0000000012345000, 3'd4, 32'h12345000, 3'd4};
    vecs[9]  = '{32'h00000033, 32'h00000000, 3'd0, 64'h0000000000000000, 3'd0, 32'h00000000, 3'd0};
    vecs[10] = '{32'h7FF08067, 32'h000007FF, 3'd1, 64'h00000000000007FF, 3'd1, 32'h000007FF, 3'd1};
    vecs[11] = '{32'hFFDFF06F, 32'hFFFFFFFC, 3'd5, 64'hFFFFFFFFFFFFFFFC, 3'd5, 32'hFFFFFFFC, 3'd5};
    vecs[12] = '{32'h00000073, 32'h00000000, 3'd1, 64'h0000000000000000, 3'd1, 32'h00000000, 3'd1};
    vecs[13] = '{32'hFFFFFFFF, 32'h00000000, 3'd0, 64'h0000000000000000, 3'd0, 32'h00000000, 3'd0};

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = 32'h0; in_tag = 8'h0; out_ready = 1'b1;
    #12;
    chk("rst_out_valid", {63'd0, a_vld}, 64'd0);
    chk("rst_out_imm", b_imm, 64'd0);
    chk("rst_out_fmt", {61'd0, a_fmt}, 64'd0);
    chk("rst_out_tag", {56'd0, a_tag}, 64'd0);
    chk("rst_in_ready", {63'd0, a_in_ready}, 64'd1);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", {63'd0, a_in_ready}, 64'd1);
    chk("post_rst_out_valid", {63'd0, a_vld}, 64'd0);

    // Back-to-back decode, one vector per cycle.
    for (int i = 0; i < NV; i++) begin
      in_valid = 1'b1; in_instr = vecs[i].instr; in_tag = 8'(8'h10 + i);
      @(posedge clk); #1;
      chk($sformatf("v%0d_valid", i), {61'd0, a_vld, b_vld, c_vld}, 64'd7);
      chk($sformatf("v%0d_tag", i), {56'd0, a_tag}, {56'd0, 8'(8'h10 + i)});
      chk($sformatf("v%0d_a_imm", i), {32'd0, a_imm}, {32'd0, vecs[i].imm_a});
      chk($sformatf("v%0d_a_fmt", i), {61'd0, a_fmt}, {61'd0, vecs[i].fmt_a});
      chk($sformatf("v%0d_b_imm", i), b_imm, vecs[i].imm_b);
      chk($sformatf("v%0d_b_fmt", i), {61'd0, b_fmt}, {61'd0, vecs[i].fmt_b});
      chk($sformatf("v%0d_c_imm", i), {32'd0, c_imm}, {32'd0, vecs[i].imm_c});
      chk($sformatf("v%0d_c_fmt", i), {61'd0, c_fmt}, {61'd0, vecs[i].fmt_c});
      @(negedge clk);
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("drain_out_valid", {63'd0, a_vld}, 64'd0);

    // Backpressure: tags 1,2,3 pushed while the output is stalled.
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'hFFF00093; in_tag = 8'd1;
    @(negedge clk); in_instr = 32'h800000B7; in_tag = 8'd2;
    @(negedge clk); in_instr = 32'h0000006F; in_tag = 8'd3;
    chk("bp_in_ready_low", {63'd0, a_in_ready}, 64'd0);
    chk("bp_head_tag", {56'd0, a_tag}, 64'd1);
    held_imm = a_imm;
    chk("bp_head_imm", {32'd0, held_imm}, 64'hFFFFFFFF);
    @(negedge clk); @(negedge clk);
    chk("bp_hold_valid", {63'd0, a_vld}, 64'd1);
    chk("bp_hold_tag", {56'd0, a_tag}, 64'd1);
    chk("bp_hold_imm", {32'd0, a_imm}, {32'd0, held_imm});
    chk("bp_hold_in_ready", {63'd0, a_in_ready}, 64'd0);
    out_ready = 1'b1;
    got.delete();
    for (int c = 0; c < 10; c++) begin
      o_fire = a_vld & out_ready;
      o_tag  = a_tag;
      i_fire = in_valid & a_in_ready;
      @(posedge clk);
      if (o_fire) got.push_back(o_tag);
      @(negedge clk);
      if (i_fire) in_valid = 1'b0;
    end
    chk("bp_count", 64'(got.size()), 64'd3);
    for (int k = 0; k < 3; k++)
      chk($sformatf("bp_order%0d", k), (k < got.size()) ? {56'd0, got[k]} : 64'hDEAD, 64'(k + 1));

    // Flush with both entries full; the blocked input in that cycle must not land.
    out_ready = 1'b0;
    in_valid = 1'b1; in_tag = 8'd4;
    @(negedge clk); in_tag = 8'd5;
    @(negedge clk); in_tag = 8'd6;
    chk("fl_full_in_ready", {63'd0, a_in_ready}, 64'd0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_out_valid", {63'd0, a_vld}, 64'd0);
    chk("fl_in_ready", {63'd0, a_in_ready}, 64'd1);
    // Input accepted-looking handshake during flush is dropped.
    in_valid = 1'b1; in_tag = 8'd7; out_ready = 1'b1; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_drop_in_valid", {63'd0, a_vld}, 64'd0);
    @(negedge clk);
    chk("fl_drop_stays_empty", {63'd0, a_vld}, 64'd0);

    // Asynchronous reset mid-stream with both entries full.
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'hFFF00093; in_tag = 8'd8;
    @(negedge clk); in_tag = 8'd9;
    @(negedge clk); in_valid = 1'b0;
    chk("ar_pre_valid", {63'd0, a_vld}, 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("ar_out_valid", {61'd0, a_vld, b_vld, c_vld}, 64'd0);
    chk("ar_out_imm", b_imm, 64'd0);
    chk("ar_out_fmt", {61'd0, a_fmt}, 64'd0);
    chk("ar_out_tag", {56'd0, a_tag}, 64'd0);
    chk("ar_in_ready", {63'd0, a_in_ready}, 64'd1);
    @(negedge clk); rst = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("ar_after_valid", {63'd0, a_vld}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imm_decode_stage.md
Name: imm_decode_stage

Overview:
- Pipelined, parametrised immediate decoder for the RV32/RV64 front end. It sits between instruction fetch and the register-read and ALU stages.
- Accepts one instruction per cycle over a valid/ready handshake.
- Produces the XLEN-wide sign- or zero-extended immediate, a format code and a passthrough tag.
- A two-entry skid buffer gives full throughput under backpressure. A synchronous flush supports branch redirect.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64.
TAG_W, 8, width of the opaque tag (PC index or ROB id) carried alongside the instruction.
EN_ZIMM, 1, 1 = decode the CSR zimm format for SYSTEM instructions; 0 = SYSTEM is decoded as plain I-type.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
flush  in  1  synchronous kill of all buffered entries
in_valid  in  1  input instruction valid
in_ready  out  1  stage can accept an input
in_instr  in  32  raw instruction word
in_tag  in  TAG_W  tag accompanying the instruction
out_valid  out  1  output entry valid
out_ready  in  1  downstream accepts the output
out_imm  out  XLEN  decoded immediate
out_fmt  out  3  format: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z
out_tag  out  TAG_W  tag of the output entry

Behaviour:
- Reset (asynchronous, active-high) values:
  - out_valid=0, out_imm=0, out_fmt=0, out_tag=0.
  - Skid entry empty.
  - in_ready=1, both during reset and after it.
- Decode is combinational on in_instr and is registered on acceptance. Latency from input handshake to out_valid is 1 cycle.
- Format selection, by opcode in_instr[6:0]:
  - 0000011 load, 0010011 OP-IMM, 1100111 JALR -> I.
  - 0011011 OP-IMM-32 -> I when XLEN=64; NONE when XLEN=32.
  - 1110011 SYSTEM:
    - Z when EN_ZIMM=1 and instr[14]=1.
    - Otherwise I.
  - 0100011 -> S.
  - 1100011 -> B.
  - 0110111 / 0010111 -> U.
  - 1101111 -> J.
  - Any other opcode -> NONE with imm=0.
- Immediate construction. All formats except Z and NONE sign-extend from instr[31] to XLEN.
  - I: instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U: {instr[31:12], 12'b0}, sign-extended to XLEN for RV64.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - Z: zero-extend instr[19:15].
- Handshake rules:
  - A transfer occurs when valid and ready are both high on a rising edge.
  - out_valid, out_imm, out_fmt and out_tag hold stable while out_valid=1 and out_ready=0.
  - in_ready is registered and equals !skid_valid.
- Skid buffer, main register M and skid register K:
  - Accept when M is empty or M is being consumed -> write M.
  - Accept while M is full and stalled -> write K; in_ready falls next cycle.
  - M consumed while K is full -> K moves to M; K empties; in_ready rises next cycle.
  - Order is strictly preserved. Back-to-back transfers give 1 instruction/cycle.
- Flush:
  - Next cycle: M and K are empty, out_valid=0, in_ready=1.
  - An input handshaking in the flush cycle is dropped.
  - An output handshake in the flush cycle still counts as delivered.
  - Flush has priority over all other updates.
- Reset mid-operation clears both entries immediately (asynchronous); no partial entry survives.
- Payload registers update only on a load; invalid entries keep their stale data.

Test Plan:
- XLEN=32, in_instr=0xFFF00093 (addi x1,x0,-1), out_ready=1 -> one cycle later: out_valid=1, out_imm=0xFFFFFFFF, out_fmt=1, out_tag echoed.
- XLEN=32, 0xFE000EE3 (beq x0,x0,-4) -> out_imm=0xFFFFFFFC, out_fmt=3. Then 0x0000006F (jal x0,0) -> out_imm=0, out_fmt=5 on the next consecutive cycle.
- XLEN=64:
  - 0x800000B7 (lui x1,0x80000) -> out_imm=0xFFFFFFFF80000000, out_fmt=4.
  - 0xFFF0809B (addiw) -> out_imm=all ones, fmt=1.
  - Same addiw with XLEN=32 -> fmt=0, imm=0.
- EN_ZIMM=1, 0x3402D073 (csrrwi x0,mscratch,5) -> out_imm=5, out_fmt=6. Same instruction with EN_ZIMM=0 -> fmt=1, imm=0x340.
- Backpressure:
  - Hold out_ready=0 and push tags 1,2,3 on consecutive cycles: tag 1 fills M, tag 2 fills K, in_ready=0 so tag 3 is held.
  - Output holds tag 1 stable.
  - Release out_ready: tags emerge in order 1,2,3; no loss, no duplication.
- Flush with M and K full -> next cycle out_valid=0, in_ready=1.
- Assert rst asynchronously mid-stream -> all outputs 0 before the next clock edge.
